argmax_classifier: RTL

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

---
 rtl/argmax_pkg.sv | 25 ++
 rtl/argmax_classifier_score_compare.sv | 12 +
 rtl/argmax_classifier.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/argmax_pkg.sv
// Shared types for the argmax classifier: FSM state encoding and Q5.27 score type.
package argmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SCAN    = 2'd2,
        ST_OUT     = 2'd3
    } state_e;

    localparam int SCORE_W = 32;

    typedef logic signed [SCORE_W-1:0] score_t;

    localparam score_t SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

    // Most negative two's-complement value of an arbitrary width.
    function automatic logic [63:0] min_of_width(input int w);
        logic [63:0] v;
        v = '0;
        v[w-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/argmax_classifier_score_compare.sv
// Combinational signed strict-greater comparator used by the argmax scan.
module score_compare #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt
);

    assign gt = $signed(a) > $signed(b);

endmodule

// File: rtl/argmax_classifier.sv
// Argmax over N_CLASSES perceptron scores: collect done bits, snapshot, serial scan, AXIS-style output.
// Optional macro ARGMAX_SCORE_OUT_EN adds the max_score output port.
module argmax_classifier
    import argmax_pkg::*;
#(
    parameter int N_CLASSES = 10,
    parameter int N_BITS    = 32,
    parameter int IDX_W     = 4
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic                          start,
    input  logic [N_CLASSES*N_BITS-1:0]   a_tdata_bus,
    input  logic [N_CLASSES-1:0]          done_bus,
    output logic [IDX_W-1:0]              class_tdata,
    output logic                          class_tvalid,
    input  logic                          class_tready,
`ifdef ARGMAX_SCORE_OUT_EN
    output logic signed [N_BITS-1:0]      max_score,
`endif
    output logic                          busy
);

    localparam logic [N_BITS-1:0] BEST_INIT = N_BITS'(min_of_width(N_BITS));
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_CLASSES - 1);

    state_e                             state_q, state_d;
    logic                               start_q;
    logic [N_CLASSES-1:0]               done_seen_q, done_seen_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [N_CLASSES-1:0][N_BITS-1:0]   scores_q, scores_d;
    logic [N_BITS-1:0]                  best_q, best_d;
    logic [IDX_W-1:0]                   best_idx_q, best_idx_d;
    logic                               tvalid_q, tvalid_d;
    logic [IDX_W-1:0]                   tdata_q, tdata_d;
`ifdef ARGMAX_SCORE_OUT_EN
    logic [N_BITS-1:0]                  max_q, max_d;
`endif

    logic              start_rise;
    logic [N_BITS-1:0] cur_score;
    logic              cur_gt;

    assign start_rise = start & ~start_q;
    assign cur_score  = scores_q[idx_q];

    score_compare #(.W(N_BITS)) u_cmp (
        .a  (cur_score),
        .b  (best_q),
        .gt (cur_gt)
    );

    always_comb begin
        state_d     = state_q;
        done_seen_d = done_seen_q;
        idx_d       = idx_q;
        scores_d    = scores_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
`ifdef ARGMAX_SCORE_OUT_EN
        max_d       = max_q;
`endif
        // A new start edge aborts whatever is in flight, including a pending handshake.
        if (start_rise) begin
            state_d     = ST_COLLECT;
            done_seen_d = '0;
            tvalid_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_COLLECT: begin
                    done_seen_d = done_seen_q | done_bus;
                    if (&(done_seen_q | done_bus)) begin
                        scores_d   = a_tdata_bus;
                        idx_d      = '0;
                        best_d     = BEST_INIT;
                        best_idx_d = '0;
                        state_d    = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cur_gt) begin
                        best_d     = cur_score;
                        best_idx_d = idx_q;
                    end
                    if (idx_q == LAST_IDX) state_d = ST_OUT;
                    else                   idx_d   = idx_q + 1'b1;
                end
                ST_OUT: begin
                    // First OUT cycle publishes the result; it then holds until accepted.
                    if (!tvalid_q) begin
                        tvalid_d = 1'b1;
                        tdata_d  = best_idx_q;
`ifdef ARGMAX_SCORE_OUT_EN
                        max_d    = best_q;
`endif
                    end else if (class_tready) begin
                        tvalid_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            done_seen_q <= '0;
            idx_q       <= '0;
            scores_q    <= '0;
            best_q      <= BEST_INIT;
            best_idx_q  <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
`ifdef ARGMAX_SCORE_OUT_EN
            max_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            done_seen_q <= done_seen_d;
            idx_q       <= idx_d;
            scores_q    <= scores_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
`ifdef ARGMAX_SCORE_OUT_EN
            max_q       <= max_d;
`endif
        end
    end

    assign class_tvalid = tvalid_q;
    assign class_tdata  = tdata_q;
    assign busy         = (state_q != ST_IDLE);
`ifdef ARGMAX_SCORE_OUT_EN
    assign max_score    = max_q;
`endif

endmodule
